// File: rtl/fifo_pkg.sv
// fifo_pkg: shared constants and helpers for the circular FIFO controller.
// Optional macro FIFO_ERR_EN (used by fifo_ctrl) adds a sticky error flag.
package fifo_pkg;

    // Geometry of the attached 10-bit x 8-entry memory.
    localparam int DEPTH  = 8;
    localparam int ADDR_W = 4;
    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_W  = PTR_W + 1;

    // Default occupancy thresholds for the almost flags.
    localparam int DEF_AF_THRESH = 6;
    localparam int DEF_AE_THRESH = 2;

    // Accepted-operation encoding, built as {rd_acc, wr_acc}.
    typedef enum logic [1:0] {
        OP_IDLE = 2'b00,
        OP_WR   = 2'b01,
        OP_RD   = 2'b10,
        OP_BOTH = 2'b11
    } op_e;

    // Pointers are narrower than the memory address port; upper bits read 0.
    function automatic logic [ADDR_W-1:0] ptr2addr(
        input logic [PTR_W-1:0] p
    );
        return {{(ADDR_W-PTR_W){1'b0}}, p};
    endfunction

endpackage

// File: rtl/fifo_ptr.sv
// fifo_ptr: wrapping pointer register (0..DEPTH-1) with increment enable.
// Ports: clk, reset (async, active-high), inc_i (advance), ptr_o (pointer).
module fifo_ptr
    import fifo_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             inc_i,
    output logic [PTR_W-1:0] ptr_o
);

    logic [PTR_W-1:0] ptr_q;
    logic [PTR_W-1:0] ptr_d;

    // Explicit wrap keeps the pointer legal even for non power-of-two depths.
    always_comb begin
        ptr_d = ptr_q;
        if (inc_i) begin
            if (ptr_q == PTR_W'(DEPTH - 1)) begin
                ptr_d = '0;
            end else begin
                ptr_d = ptr_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr_o = ptr_q;

endmodule

// File: rtl/fifo_ctrl.sv
// fifo_ctrl: pointer/flag controller running the dual-address memory as a FIFO.
// Ports: clk, reset, push, pop in; memory enables/addresses/clear, flags,
// count and data_valid out. With FIFO_ERR_EN: err_clr in, sticky err out.
module fifo_ctrl
    import fifo_pkg::*;
#(
    parameter int AF_THRESH = DEF_AF_THRESH,
    parameter int AE_THRESH = DEF_AE_THRESH
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic              pop,
    output logic              mem_wr_en,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_wr_add,
    output logic [ADDR_W-1:0] mem_rd_add,
    output logic              mem_reset_L,
    output logic              data_valid,
    output logic              full,
    output logic              empty,
    output logic              almost_full,
    output logic              almost_empty,
    output logic [CNT_W-1:0]  count
`ifdef FIFO_ERR_EN
    ,
    input  logic              err_clr,
    output logic              err
`endif
);

    logic             wr_acc;
    logic             rd_acc;
    op_e              op;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic             data_valid_q;

    // Flags decode only the registered count, so they never glitch on push/pop.
    assign full         = (count_q == CNT_W'(DEPTH));
    assign empty        = (count_q == '0);
    assign almost_full  = (count_q >= CNT_W'(AF_THRESH));
    assign almost_empty = (count_q <= CNT_W'(AE_THRESH));
    assign count        = count_q;

    // Full gives priority to the read, empty to the write; no bypass path.
    assign wr_acc = push & ~full;
    assign rd_acc = pop & ~empty;
    assign op     = op_e'({rd_acc, wr_acc});

    assign mem_wr_en   = wr_acc;
    assign mem_rd_en   = rd_acc;
    assign mem_wr_add  = ptr2addr(wr_ptr);
    assign mem_rd_add  = ptr2addr(rd_ptr);
    assign mem_reset_L = ~reset;
    assign data_valid  = data_valid_q;

    fifo_ptr u_wr_ptr (
        .clk   (clk),
        .reset (reset),
        .inc_i (wr_acc),
        .ptr_o (wr_ptr)
    );

    fifo_ptr u_rd_ptr (
        .clk   (clk),
        .reset (reset),
        .inc_i (rd_acc),
        .ptr_o (rd_ptr)
    );

    always_comb begin
        count_d = count_q;
        unique case (op)
            OP_WR:   count_d = count_q + CNT_W'(1);
            OP_RD:   count_d = count_q - CNT_W'(1);
            OP_BOTH: count_d = count_q;
            default: count_d = count_q;
        endcase
    end

    // data_valid tracks the memory's one-cycle registered read latency.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q      <= '0;
            data_valid_q <= 1'b0;
        end else begin
            count_q      <= count_d;
            data_valid_q <= rd_acc;
        end
    end

`ifdef FIFO_ERR_EN
    logic err_q;
    logic err_d;
    logic err_set;

    // Overflow/underflow attempts; a new event outranks a same-cycle clear.
    assign err_set = (push & full) | (pop & empty);

    always_comb begin
        err_d = err_q;
        if (err_clr) begin
            err_d = 1'b0;
        end
        if (err_set) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err = err_q;
`endif

endmodule

// File: tb/tb_fifo_ctrl.sv
// tb_fifo_ctrl: self-checking bench for fifo_ctrl with a memory model
// and a queue-based reference of FIFO contents.
module tb_fifo_ctrl;
    import fifo_pkg::*;

    logic              clk = 1'b0;
    logic              reset;
    logic              push;
    logic              pop;
    logic              mem_wr_en;
    logic              mem_rd_en;
    logic [ADDR_W-1:0] mem_wr_add;
    logic [ADDR_W-1:0] mem_rd_add;
    logic              mem_reset_L;
    logic              data_valid;
    logic              full;
    logic              empty;
    logic              almost_full;
    logic              almost_empty;
    logic [CNT_W-1:0]  count;
`ifdef FIFO_ERR_EN
    logic              err_clr;
    logic              err;
`endif

    logic [9:0] wdata;
    logic [9:0] mem [0:(1<<ADDR_W)-1];
    logic [9:0] rd_q;

    int n_chk = 0;
    int n_pass = 0;
    int q[$];
    int nw = 0;
    int nr = 0;
    int exp_word = 0;
    bit err_m = 0;

    typedef struct {
        bit p;
        bit o;
        int cnt;
        bit fl;
        bit em;
        bit af;
        bit ae;
        bit dv;
    } vec_t;
    vec_t tbl[$];

    always #5 clk = ~clk;

    fifo_ctrl dut (
        .clk          (clk),
        .reset        (reset),
        .push         (push),
        .pop          (pop),
        .mem_wr_en    (mem_wr_en),
        .mem_rd_en    (mem_rd_en),
        .mem_wr_add   (mem_wr_add),
        .mem_rd_add   (mem_rd_add),
        .mem_reset_L  (mem_reset_L),
        .data_valid   (data_valid),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .count        (count)
`ifdef FIFO_ERR_EN
        ,
        .err_clr      (err_clr),
        .err          (err)
`endif
    );

    // Model of the memory: sync active-low clear, registered read port.
    always @(posedge clk) begin
        if (!mem_reset_L) begin
            for (int i = 0; i < (1 << ADDR_W); i++) mem[i] <= '0;
            rd_q <= '0;
        end else begin
            if (mem_wr_en) mem[mem_wr_add] <= wdata;
            if (mem_rd_en) rd_q <= mem[mem_rd_add];
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endtask

    function automatic vec_t mk(bit p, bit o, int c, bit fl, bit em,
                                bit af, bit ae, bit dv);
        vec_t v;
        v.p = p; v.o = o; v.cnt = c; v.fl = fl;
        v.em = em; v.af = af; v.ae = ae; v.dv = dv;
        return v;
    endfunction

    // One clock of stimulus, checked against the queue model.
    task automatic step(input bit p, input bit o, input bit c);
        bit wa;
        bit ra;
        @(negedge clk);
        push = p;
        pop = o;
        wdata = 10'($urandom);
`ifdef FIFO_ERR_EN
        err_clr = c;
`endif
        wa = p && (q.size() < DEPTH);
        ra = o && (q.size() > 0);
        if ((p && q.size() == DEPTH) || (o && q.size() == 0)) err_m = 1;
        else if (c) err_m = 0;
        #1;
        chk("mem_wr_en", mem_wr_en, wa);
        chk("mem_rd_en", mem_rd_en, ra);
        if (wa) chk("mem_wr_add", mem_wr_add, nw % DEPTH);
        if (ra) chk("mem_rd_add", mem_rd_add, nr % DEPTH);
        @(posedge clk);
        if (wa) begin
            q.push_back(int'(wdata));
            nw++;
        end
        if (ra) begin
            exp_word = q.pop_front();
            nr++;
        end
        #1;
        chk("count", count, q.size());
        chk("full", full, q.size() == DEPTH);
        chk("empty", empty, q.size() == 0);
        chk("almost_full", almost_full, q.size() >= DEF_AF_THRESH);
        chk("almost_empty", almost_empty, q.size() <= DEF_AE_THRESH);
        chk("data_valid", data_valid, ra);
        if (ra) chk("rd_data", rd_q, exp_word);
`ifdef FIFO_ERR_EN
        chk("err", err, err_m);
`endif
    endtask

    // Reset asserted between clock edges; outputs must react at once.
    task automatic mid_reset();
        #2;
        reset = 1;
        #1;
        chk("rst_count", count, 0);
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_ae", almost_empty, 1);
        chk("rst_af", almost_full, 0);
        chk("rst_dv", data_valid, 0);
        chk("rst_mem_reset_L", mem_reset_L, 0);
`ifdef FIFO_ERR_EN
        chk("rst_err", err, 0);
`endif
        q.delete();
        nw = 0;
        nr = 0;
        err_m = 0;
        @(negedge clk);
        push = 0;
        pop = 0;
        @(negedge clk);
        reset = 0;
        #1;
        chk("rel_mem_reset_L", mem_reset_L, 1);
    endtask

    initial begin
        reset = 1;
        push = 0;
        pop = 0;
        wdata = '0;
`ifdef FIFO_ERR_EN
        err_clr = 0;
`endif
        // Push phase from empty, overflow attempt, pop phase, underflow.
        tbl.push_back(mk(1, 0, 1, 0, 0, 0, 1, 0));
        tbl.push_back(mk(1, 0, 2, 0, 0, 0, 1, 0));
        tbl.push_back(mk(1, 0, 3, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 0, 4, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 0, 5, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 0, 6, 0, 0, 1, 0, 0));
        tbl.push_back(mk(1, 0, 7, 0, 0, 1, 0, 0));
        tbl.push_back(mk(1, 0, 8, 1, 0, 1, 0, 0));
        tbl.push_back(mk(1, 0, 8, 1, 0, 1, 0, 0));
        tbl.push_back(mk(0, 1, 7, 0, 0, 1, 0, 1));
        tbl.push_back(mk(0, 1, 6, 0, 0, 1, 0, 1));
        tbl.push_back(mk(0, 1, 5, 0, 0, 0, 0, 1));
        tbl.push_back(mk(0, 1, 4, 0, 0, 0, 0, 1));
        tbl.push_back(mk(0, 1, 3, 0, 0, 0, 0, 1));
        tbl.push_back(mk(0, 1, 2, 0, 0, 0, 1, 1));
        tbl.push_back(mk(0, 1, 1, 0, 0, 0, 1, 1));
        tbl.push_back(mk(0, 1, 0, 0, 1, 0, 1, 1));
        tbl.push_back(mk(0, 1, 0, 0, 1, 0, 1, 0));

        repeat (2) @(negedge clk);
        reset = 0;
        #1;
        chk("init_empty", empty, 1);
        chk("init_count", count, 0);

        // Reset mid-cycle with data present.
        step(1, 0, 0);
        step(1, 0, 0);
        mid_reset();

        foreach (tbl[i]) begin
            step(tbl[i].p, tbl[i].o, 0);
            chk($sformatf("tbl%0d_count", i), count, tbl[i].cnt);
            chk($sformatf("tbl%0d_full", i), full, tbl[i].fl);
            chk($sformatf("tbl%0d_empty", i), empty, tbl[i].em);
            chk($sformatf("tbl%0d_af", i), almost_full, tbl[i].af);
            chk($sformatf("tbl%0d_ae", i), almost_empty, tbl[i].ae);
            chk($sformatf("tbl%0d_dv", i), data_valid, tbl[i].dv);
        end

        // Simultaneous push/pop at count 3 across pointer wrap.
        repeat (3) step(1, 0, 0);
        for (int i = 0; i < 10; i++) begin
            step(1, 1, 0);
            chk("pp3_count", count, 3);
        end
        repeat (3) step(0, 1, 0);

        // Push/pop when full, then when empty.
        repeat (8) step(1, 0, 0);
        step(1, 1, 0);
        chk("pp_full_count", count, 7);
        repeat (7) step(0, 1, 0);
        step(1, 1, 0);
        chk("pp_empty_count", count, 1);
        chk("pp_empty_dv", data_valid, 0);
        step(0, 1, 0);

        // Reset with count 5 right after an accepted pop.
        repeat (6) step(1, 0, 0);
        step(0, 1, 0);
        chk("pre_rst_count", count, 5);
        chk("pre_rst_dv", data_valid, 1);
        mid_reset();
        step(1, 0, 0);
        chk("post_rst_count", count, 1);
        step(0, 1, 0);

        // Randomized phases: fill-biased, drain-biased, balanced.
        for (int i = 0; i < 600; i++) begin
            int pp;
            int op;
            case ((i / 50) % 3)
                0: begin pp = 75; op = 30; end
                1: begin pp = 30; op = 75; end
                default: begin pp = 50; op = 50; end
            endcase
            step($urandom_range(0, 99) < pp,
                 $urandom_range(0, 99) < op,
                 $urandom_range(0, 15) == 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
